// File: rtl/issue_scheduler.sv
// In-order dual-issue scheduler: register scoreboard, unit reservation checks and hazard-stall counting
// between decode and the execution units.
module issue_scheduler #(
  parameter int FRONTEND_WIDTH = 2,
  parameter int NB_UNIT        = 6,
  parameter int NB_REGS        = 5
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [FRONTEND_WIDTH-1:0]               dec_valid_i,
  input  logic [FRONTEND_WIDTH-1:0][NB_UNIT-1:0]  dec_unit_i,
  input  logic [FRONTEND_WIDTH-1:0][NB_REGS-1:0]  dec_rd_i,
  input  logic [FRONTEND_WIDTH-1:0]               dec_rd_v_i,
  input  logic [FRONTEND_WIDTH-1:0][NB_REGS-1:0]  dec_rs1_i,
  input  logic [FRONTEND_WIDTH-1:0][NB_REGS-1:0]  dec_rs2_i,
  input  logic [FRONTEND_WIDTH-1:0][1:0]          dec_rs_v_i,
  output logic [FRONTEND_WIDTH-1:0]               dec_accept_o,
  input  logic [NB_UNIT-1:0]                      unit_busy_i,
  output logic [FRONTEND_WIDTH-1:0]               iss_valid_o,
  output logic [FRONTEND_WIDTH-1:0][NB_UNIT-1:0]  iss_unit_o,
  output logic [FRONTEND_WIDTH-1:0][NB_REGS-1:0]  iss_rd_o,
  output logic [FRONTEND_WIDTH-1:0]               iss_rd_v_o,
  input  logic [1:0]                              wb_valid_i,
  input  logic [1:0][NB_REGS-1:0]                 wb_rd_i,
  input  logic                                    flush_i,
  output logic [(1<<NB_REGS)-1:0]                 sb_busy_o,
  output logic [31:0]                             stall_cnt_o
);

  localparam int NB_ARCH = 1 << NB_REGS;

  logic [NB_ARCH-1:0]        sb_q;
  logic [NB_ARCH-1:0]        sb_d;
  logic [FRONTEND_WIDTH-1:0] unit_ok;
  logic [FRONTEND_WIDTH-1:0] hazard_ok;
  logic [FRONTEND_WIDTH-1:0] issue;
  logic                      pair_dep;
  logic                      hazard_stall;
  logic [31:0]               stall_q;

  // Hazards look only at the registered scoreboard, so a writeback helps from the next cycle on.
  always_comb begin
    unit_ok   = '0;
    hazard_ok = '0;
    for (int s = 0; s < FRONTEND_WIDTH; s++) begin
      unit_ok[s]   = ~|(dec_unit_i[s] & unit_busy_i);
      hazard_ok[s] = !((dec_rs_v_i[s][0] && sb_q[dec_rs1_i[s]]) ||
                       (dec_rs_v_i[s][1] && sb_q[dec_rs2_i[s]]) ||
                       (dec_rd_v_i[s]    && sb_q[dec_rd_i[s]]));
    end
  end

  assign pair_dep = dec_rd_v_i[0] && (dec_rd_i[0] != '0) &&
                    ((dec_rs_v_i[1][0] && (dec_rs1_i[1] == dec_rd_i[0])) ||
                     (dec_rs_v_i[1][1] && (dec_rs2_i[1] == dec_rd_i[0])) ||
                     (dec_rd_v_i[1]    && (dec_rd_i[1]  == dec_rd_i[0])));

  assign issue[0] = !flush_i && dec_valid_i[0] && unit_ok[0] && hazard_ok[0];
  assign issue[1] = issue[0] && dec_valid_i[1] && unit_ok[1] && hazard_ok[1] &&
                    (dec_unit_i[0] != dec_unit_i[1]) && !pair_dep;

  assign dec_accept_o = issue;
  assign hazard_stall = dec_valid_i[0] && !flush_i && !hazard_ok[0];

  // Clears are applied before sets so a new producer wins over a same-cycle writeback.
  always_comb begin
    sb_d = sb_q;
    for (int w = 0; w < 2; w++) begin
      if (wb_valid_i[w]) sb_d[wb_rd_i[w]] = 1'b0;
    end
    for (int s = 0; s < FRONTEND_WIDTH; s++) begin
      if (issue[s] && dec_rd_v_i[s]) sb_d[dec_rd_i[s]] = 1'b1;
    end
    sb_d[0] = 1'b0;
    if (flush_i) sb_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q        <= '0;
      stall_q     <= '0;
      iss_valid_o <= '0;
      iss_unit_o  <= '0;
      iss_rd_o    <= '0;
      iss_rd_v_o  <= '0;
    end else begin
      sb_q <= sb_d;
      if (hazard_stall) stall_q <= stall_q + 32'd1;
      for (int s = 0; s < FRONTEND_WIDTH; s++) begin
        iss_valid_o[s] <= issue[s];
        if (issue[s]) begin
          iss_unit_o[s] <= dec_unit_i[s];
          iss_rd_o[s]   <= dec_rd_i[s];
          iss_rd_v_o[s] <= dec_rd_v_i[s];
        end
      end
    end
  end

  assign sb_busy_o   = sb_q;
  assign stall_cnt_o = stall_q;

endmodule
